// File: rtl/nfc_cmd_decoder_if.sv
// nfc_cmd_decoder_if: bus bundles used by nfc_cmd_decoder.
//  nfc_cmd_if   host command channel (master = host, slave = decoder)
//   opcode[5:0], targetID[4:0], sourceID[4:0], address[31:0], length[15:0],
//   cmdValid (host -> decoder), cmdReady (decoder -> host)
//  nfc_exec_if  executor request channel (master = decoder, slave = executor)
//   opcode, targetID, sourceID, length, way[NumberOfWays-1:0], colAddr[15:0],
//   rowAddr[23:0], valid (decoder -> executor); ready, done (executor -> decoder)
interface nfc_cmd_if;
    logic [5:0]  opcode;
    logic [4:0]  targetID;
    logic [4:0]  sourceID;
    logic [31:0] address;
    logic [15:0] length;
    logic        cmdValid;
    logic        cmdReady;
    modport master (output opcode, targetID, sourceID, address, length, cmdValid, input cmdReady);
    modport slave (input opcode, targetID, sourceID, address, length, cmdValid, output cmdReady);
endinterface

interface nfc_exec_if #(parameter int NumberOfWays = 2);
    logic [5:0]              opcode;
    logic [4:0]              targetID;
    logic [4:0]              sourceID;
    logic [15:0]             length;
    logic [NumberOfWays-1:0] way;
    logic [15:0]             colAddr;
    logic [23:0]             rowAddr;
    logic                    valid;
    logic                    ready;
    logic                    done;
    modport master (output opcode, targetID, sourceID, length, way, colAddr, rowAddr, valid,
                    input ready, done);
    modport slave (input opcode, targetID, sourceID, length, way, colAddr, rowAddr, valid,
                   output ready, done);
endinterface

// File: rtl/nfc_cmd_decoder.sv
// nfc_cmd_decoder: host command responder for the NAND flash controller.
//  Register opcodes (way/column/row) are absorbed locally; NAND operation opcodes
//  1..7 are forwarded to the executor with a snapshot of way/column/row, and the
//  host is held off (cmdReady low) until the executor signals done.
// Ports:
//  iSystemClock  system clock, rising edge
//  iReset_n      asynchronous active-low reset
//  cmdBus        nfc_cmd_if.slave   host command channel
//  execBus       nfc_exec_if.master executor request channel
//  oActiveWay    current one-hot way register
//  oIllegal      one-cycle pulse on a rejected command
// Configuration macro:
//  NFC_ROW_AUTOINC_EN  row register increments (mod 2^24) on completion of
//                      program (6'b000011) and read page (6'b000100).
module nfc_cmd_decoder #(
    parameter int                    NumberOfWays = 2,
    parameter logic [NumberOfWays-1:0] DefaultWay = NumberOfWays'(1)
) (
    input  logic              iSystemClock,
    input  logic              iReset_n,
    nfc_cmd_if.slave          cmdBus,
    nfc_exec_if.master        execBus,
    output logic [NumberOfWays-1:0] oActiveWay,
    output logic              oIllegal
);
    typedef enum logic [1:0] {Idle, Dispatch, WaitDone} state_t;

    state_t state, nextState;

    logic [NumberOfWays-1:0] wayReg;
    logic [15:0]             colReg;
    logic [23:0]             rowReg;
    logic                    illegal;
    logic [5:0]              exOpcode;
    logic [4:0]              exTarget;
    logic [4:0]              exSource;
    logic [15:0]             exLength;
    logic [NumberOfWays-1:0] exWay;
    logic [15:0]             exCol;
    logic [23:0]             exRow;

    logic accept, isWayWr, isColWr, isRowWr, isNandOp, wayLegal;

    assign accept   = (state == Idle) && cmdBus.cmdValid;
    assign isWayWr  = cmdBus.opcode == 6'b100000;
    assign isColWr  = cmdBus.opcode == 6'b100010;
    assign isRowWr  = cmdBus.opcode == 6'b100100;
    assign isNandOp = cmdBus.opcode inside {[6'd1:6'd7]};
    // A way write is legal only if the way field is one-hot and the rest of the
    // low address byte is clear.
    assign wayLegal = $onehot(cmdBus.address[NumberOfWays-1:0]) &&
                      ((cmdBus.address[7:0] >> NumberOfWays) == 8'd0);

    always_ff @(posedge iSystemClock or negedge iReset_n) begin
        if (!iReset_n) state <= Idle;
        else           state <= nextState;
    end

    always_comb begin
        nextState = (state == Idle && accept && isNandOp)   ? Dispatch :
                    (state == Dispatch && execBus.ready)    ? WaitDone :
                    (state == WaitDone && execBus.done)     ? Idle     : state;
    end

    always_comb begin
        cmdBus.cmdReady = state == Idle;
        execBus.valid   = state == Dispatch;
    end

    always_ff @(posedge iSystemClock or negedge iReset_n) begin
        if (!iReset_n) begin
            wayReg   <= DefaultWay;
            colReg   <= '0;
            rowReg   <= '0;
            illegal  <= 1'b0;
            exOpcode <= '0;
            exTarget <= '0;
            exSource <= '0;
            exLength <= '0;
            exWay    <= '0;
            exCol    <= '0;
            exRow    <= '0;
        end else begin
            illegal <= 1'b0;
            if (accept) begin
                if (isWayWr) begin
                    if (wayLegal) wayReg <= cmdBus.address[NumberOfWays-1:0];
                    else          illegal <= 1'b1;
                end else if (isColWr) begin
                    colReg <= cmdBus.address[15:0];
                end else if (isRowWr) begin
                    rowReg <= cmdBus.address[23:0];
                end else if (isNandOp) begin
                    // Snapshot so later register writes cannot disturb this operation.
                    exOpcode <= cmdBus.opcode;
                    exTarget <= cmdBus.targetID;
                    exSource <= cmdBus.sourceID;
                    exLength <= cmdBus.length;
                    exWay    <= wayReg;
                    exCol    <= colReg;
                    exRow    <= rowReg;
                end else begin
                    illegal <= 1'b1;
                end
            end
`ifdef NFC_ROW_AUTOINC_EN
            // Cannot collide with a row write: those are only accepted in Idle.
            if (state == WaitDone && execBus.done && (exOpcode == 6'b000011 || exOpcode == 6'b000100))
                rowReg <= rowReg + 24'd1;
`endif
        end
    end

    assign execBus.opcode   = exOpcode;
    assign execBus.targetID = exTarget;
    assign execBus.sourceID = exSource;
    assign execBus.length   = exLength;
    assign execBus.way      = exWay;
    assign execBus.colAddr  = exCol;
    assign execBus.rowAddr  = exRow;
    assign oActiveWay       = wayReg;
    assign oIllegal         = illegal;
endmodule

// File: tb/tb_nfc_cmd_decoder.sv
// tb_nfc_cmd_decoder: self-checking bench for nfc_cmd_decoder against a behavioural model.
module tb_nfc_cmd_decoder;
    localparam int NW = 2;
`ifdef NFC_ROW_AUTOINC_EN
    localparam bit AutoInc = 1'b1;
`else
    localparam bit AutoInc = 1'b0;
`endif

    logic iSystemClock = 1'b0;
    logic iReset_n = 1'b0;
    logic [NW-1:0] oActiveWay;
    logic oIllegal;
    int errors = 0;
    int checks = 0;

    int mWay, mCol, mRow;

    nfc_cmd_if cmdBus();
    nfc_exec_if #(.NumberOfWays(NW)) execBus();

    nfc_cmd_decoder #(.NumberOfWays(NW), .DefaultWay(2'b01)) dut (
        .iSystemClock(iSystemClock),
        .iReset_n(iReset_n),
        .cmdBus(cmdBus.slave),
        .execBus(execBus.master),
        .oActiveWay(oActiveWay),
        .oIllegal(oIllegal)
    );

    always #5 iSystemClock = ~iSystemClock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge iSystemClock);
        #1;
    endtask

    task automatic sendCmd(input logic [5:0] op, input logic [31:0] addr, input logic [4:0] tgt,
                           input logic [4:0] src, input logic [15:0] len);
        cmdBus.opcode = op;
        cmdBus.address = addr;
        cmdBus.targetID = tgt;
        cmdBus.sourceID = src;
        cmdBus.length = len;
        cmdBus.cmdValid = 1'b1;
        tick();
        cmdBus.cmdValid = 1'b0;
    endtask

    task automatic runExec(input int hold);
        repeat (hold) tick();
        execBus.ready = 1'b1;
        tick();
        execBus.ready = 1'b0;
        tick();
        execBus.done = 1'b1;
        tick();
        execBus.done = 1'b0;
    endtask

    function automatic void modelDone(input int op);
        if (AutoInc && (op == 3 || op == 4)) mRow = (mRow + 1) % (1 << 24);
    endfunction

    task automatic doReset();
        iReset_n = 1'b0;
        tick();
        tick();
        iReset_n = 1'b1;
        tick();
        mWay = 1;
        mCol = 0;
        mRow = 0;
    endtask

    task automatic test_reset();
        doReset();
        checks++;
        if (cmdBus.cmdReady !== 1'b1 || execBus.valid !== 1'b0 || oIllegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: ready=%b valid=%b illegal=%b want 1 0 0", cmdBus.cmdReady, execBus.valid, oIllegal);
        end
        checks++;
        if (oActiveWay !== 2'b01) begin
            errors++;
            $display("FAIL reset_way: got %b want 01", oActiveWay);
        end
        checks++;
        if ({execBus.opcode, execBus.targetID, execBus.sourceID, execBus.length, execBus.way, execBus.colAddr, execBus.rowAddr} !== '0) begin
            errors++;
            $display("FAIL reset_exec: op=%h row=%h col=%h want all zero", execBus.opcode, execBus.rowAddr, execBus.colAddr);
        end
        sendCmd(6'd1, 32'h0, 5'd2, 5'd3, 16'd4);
        checks++;
        if (execBus.valid !== 1'b1 || execBus.colAddr !== 16'h0 || execBus.rowAddr !== 24'h0 || execBus.way !== 2'b01) begin
            errors++;
            $display("FAIL reset_regs: valid=%b col=%h row=%h way=%b want 1 0 0 01", execBus.valid, execBus.colAddr, execBus.rowAddr, execBus.way);
        end
        runExec(0);
    endtask

    task automatic test_way();
        sendCmd(6'b100000, 32'h02, 5'd0, 5'd0, 16'd0);
        mWay = 2;
        checks++;
        if (oActiveWay !== 2'b10 || cmdBus.cmdReady !== 1'b1 || oIllegal !== 1'b0) begin
            errors++;
            $display("FAIL way_write: way=%b ready=%b illegal=%b want 10 1 0", oActiveWay, cmdBus.cmdReady, oIllegal);
        end
        for (int i = 0; i < 3; i++) begin
            logic [31:0] bad;
            bad = (i == 0) ? 32'h00 : (i == 1) ? 32'h03 : 32'h06;
            sendCmd(6'b100000, bad, 5'd0, 5'd0, 16'd0);
            checks++;
            if (oIllegal !== 1'b1 || oActiveWay !== 2'b10 || cmdBus.cmdReady !== 1'b1) begin
                errors++;
                $display("FAIL way_illegal addr=%h: illegal=%b way=%b ready=%b want 1 10 1", bad, oIllegal, oActiveWay, cmdBus.cmdReady);
            end
            tick();
            checks++;
            if (oIllegal !== 1'b0) begin
                errors++;
                $display("FAIL way_illegal_pulse addr=%h: illegal=%b want 0", bad, oIllegal);
            end
        end
    endtask

    task automatic test_dispatch_and_wait();
        logic [71:0] want;
        sendCmd(6'b100100, 32'h000003, 5'd0, 5'd0, 16'd0);
        mRow = 3;
        sendCmd(6'b000011, 32'h0, 5'd0, 5'd9, 16'd8);
        want = {6'b000011, 5'd0, 5'd9, 16'd8, NW'(mWay), 16'(mCol), 24'(mRow)};
        checks++;
        if (cmdBus.cmdReady !== 1'b0 || execBus.valid !== 1'b1) begin
            errors++;
            $display("FAIL dispatch_hs: ready=%b valid=%b want 0 1", cmdBus.cmdReady, execBus.valid);
        end
        checks++;
        if (execBus.rowAddr !== 24'h3 || execBus.colAddr !== 16'h0) begin
            errors++;
            $display("FAIL dispatch_addr: row=%h col=%h want 3 0", execBus.rowAddr, execBus.colAddr);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({execBus.opcode, execBus.targetID, execBus.sourceID, execBus.length, execBus.way, execBus.colAddr, execBus.rowAddr} !== want || execBus.valid !== 1'b1) begin
                errors++;
                $display("FAIL dispatch_hold%0d: fields=%h valid=%b want %h 1", i,
                         {execBus.opcode, execBus.targetID, execBus.sourceID, execBus.length, execBus.way, execBus.colAddr, execBus.rowAddr}, execBus.valid, want);
            end
            tick();
        end
        execBus.ready = 1'b1;
        tick();
        execBus.ready = 1'b0;
        checks++;
        if (cmdBus.cmdReady !== 1'b0 || execBus.valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_hs: ready=%b valid=%b want 0 0", cmdBus.cmdReady, execBus.valid);
        end
        sendCmd(6'b100100, 32'h55, 5'd0, 5'd0, 16'd0);
        sendCmd(6'b000111, 32'h0, 5'd1, 5'd1, 16'd1);
        tick();
        checks++;
        if (cmdBus.cmdReady !== 1'b0 || execBus.valid !== 1'b0 || execBus.opcode !== 6'b000011) begin
            errors++;
            $display("FAIL wait_ignore: ready=%b valid=%b op=%h want 0 0 03", cmdBus.cmdReady, execBus.valid, execBus.opcode);
        end
        execBus.done = 1'b1;
        tick();
        execBus.done = 1'b0;
        modelDone(3);
        checks++;
        if (cmdBus.cmdReady !== 1'b1 || execBus.valid !== 1'b0) begin
            errors++;
            $display("FAIL done_ready: ready=%b valid=%b want 1 0", cmdBus.cmdReady, execBus.valid);
        end
        sendCmd(6'b000110, 32'h0, 5'd0, 5'd0, 16'd0);
        checks++;
        if (execBus.rowAddr !== 24'(mRow) || execBus.valid !== 1'b1) begin
            errors++;
            $display("FAIL wait_row_kept: row=%h valid=%b want %h 1", execBus.rowAddr, execBus.valid, mRow);
        end
        runExec(1);
        modelDone(6);
    endtask

    task automatic test_reset_mid();
        sendCmd(6'b000001, 32'h0, 5'd4, 5'd4, 16'd4);
        checks++;
        if (execBus.valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_dispatch: valid=%b want 1", execBus.valid);
        end
        iReset_n = 1'b0;
        #1;
        mWay = 1;
        mCol = 0;
        mRow = 0;
        checks++;
        if (execBus.valid !== 1'b0 || cmdBus.cmdReady !== 1'b1 || oActiveWay !== 2'b01) begin
            errors++;
            $display("FAIL mid_reset: valid=%b ready=%b way=%b want 0 1 01", execBus.valid, cmdBus.cmdReady, oActiveWay);
        end
        tick();
        iReset_n = 1'b1;
        tick();
        execBus.done = 1'b1;
        tick();
        execBus.done = 1'b0;
        tick();
        checks++;
        if (execBus.valid !== 1'b0 || cmdBus.cmdReady !== 1'b1 || oIllegal !== 1'b0) begin
            errors++;
            $display("FAIL mid_late_done: valid=%b ready=%b illegal=%b want 0 1 0", execBus.valid, cmdBus.cmdReady, oIllegal);
        end
    endtask

    task automatic test_row_wrap();
        sendCmd(6'b100100, 32'h00FF_FFFF, 5'd0, 5'd0, 16'd0);
        mRow = 24'hFF_FFFF;
        sendCmd(6'b000011, 32'h0, 5'd0, 5'd0, 16'd8);
        runExec(0);
        modelDone(3);
        sendCmd(6'b000110, 32'h0, 5'd0, 5'd0, 16'd0);
        checks++;
        if (execBus.rowAddr !== 24'(mRow)) begin
            errors++;
            $display("FAIL row_wrap: row=%h want %h", execBus.rowAddr, mRow);
        end
        runExec(0);
        modelDone(6);
        sendCmd(6'b000001, 32'h0, 5'd0, 5'd0, 16'd0);
        checks++;
        if (execBus.rowAddr !== 24'(mRow)) begin
            errors++;
            $display("FAIL row_erase_keep: row=%h want %h", execBus.rowAddr, mRow);
        end
        runExec(0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            int kind;
            logic [31:0] addr;
            logic [5:0] op;
            logic [4:0] tgt, src;
            logic [15:0] len;
            kind = $urandom_range(0, 4);
            addr = $urandom;
            tgt = 5'($urandom);
            src = 5'($urandom);
            len = 16'($urandom);
            if (kind == 0) begin
                addr = 32'($urandom_range(0, 4)) | (($urandom_range(0, 3) == 0) ? 32'h10 : 32'h0) | (addr & 32'hFFFF_FF00);
                sendCmd(6'b100000, addr, tgt, src, len);
                if (addr[7:0] == 8'd1 || addr[7:0] == 8'd2) mWay = int'(addr[7:0]);
                checks++;
                if (oIllegal !== !(addr[7:0] == 8'd1 || addr[7:0] == 8'd2) || oActiveWay !== NW'(mWay)) begin
                    errors++;
                    $display("FAIL rnd_way addr=%h: illegal=%b way=%b want way %0d", addr, oIllegal, oActiveWay, mWay);
                end
            end else if (kind == 1) begin
                sendCmd(6'b100010, addr, tgt, src, len);
                mCol = int'(addr[15:0]);
            end else if (kind == 2) begin
                sendCmd(6'b100100, addr, tgt, src, len);
                mRow = int'(addr[23:0]);
            end else begin
                op = (kind == 3) ? 6'($urandom_range(1, 7)) : 6'($urandom_range(0, 63));
                if (op == 6'h20 || op == 6'h22 || op == 6'h24) op = 6'h3F;
                sendCmd(op, addr, tgt, src, len);
                if (op >= 6'd1 && op <= 6'd7) begin
                    checks++;
                    if ({execBus.opcode, execBus.targetID, execBus.sourceID, execBus.length, execBus.way, execBus.colAddr, execBus.rowAddr}
                        !== {op, tgt, src, len, NW'(mWay), 16'(mCol), 24'(mRow)} || execBus.valid !== 1'b1 || cmdBus.cmdReady !== 1'b0) begin
                        errors++;
                        $display("FAIL rnd_op%0d: op=%h way=%b col=%h row=%h valid=%b want op=%h way=%0d col=%h row=%h valid=1",
                                 n, execBus.opcode, execBus.way, execBus.colAddr, execBus.rowAddr, execBus.valid, op, mWay, mCol, mRow);
                    end
                    runExec($urandom_range(0, 3));
                    modelDone(int'(op));
                    checks++;
                    if (cmdBus.cmdReady !== 1'b1 || execBus.valid !== 1'b0) begin
                        errors++;
                        $display("FAIL rnd_done%0d: ready=%b valid=%b want 1 0", n, cmdBus.cmdReady, execBus.valid);
                    end
                end else begin
                    checks++;
                    if (oIllegal !== 1'b1 || cmdBus.cmdReady !== 1'b1 || execBus.valid !== 1'b0) begin
                        errors++;
                        $display("FAIL rnd_illegal op=%h: illegal=%b ready=%b valid=%b want 1 1 0", op, oIllegal, cmdBus.cmdReady, execBus.valid);
                    end
                end
            end
        end
    endtask

    initial begin
        cmdBus.opcode = '0;
        cmdBus.targetID = '0;
        cmdBus.sourceID = '0;
        cmdBus.address = '0;
        cmdBus.length = '0;
        cmdBus.cmdValid = 1'b0;
        execBus.ready = 1'b0;
        execBus.done = 1'b0;
        test_reset();
        test_way();
        test_dispatch_and_wait();
        test_reset_mid();
        test_row_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
